// File: rtl/audio_pkg.sv
// Shared constants and helpers for the 48 kHz voice mixer.
// Slot map: 0..NVOICE-1 voices, EV_LATCH latches the mix, EV_CLEAR clears it.
package audio_pkg;

    localparam int NVOICE   = 32;
    localparam int PHASE_W  = 24;
    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = SAMPLE_W + 5;
    localparam int SHIFT    = 2;
    localparam int NSLOT    = 37;
    localparam int IDX_W    = 5;

    localparam int EV_LATCH = 33;
    localparam int EV_CLEAR = 34;

    localparam logic signed [ACC_W-1:0] SAT_HI =
        ACC_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    function automatic logic signed [SAMPLE_W-1:0] sat_shift(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s > SAT_HI)
            return SAT_HI[SAMPLE_W-1:0];
        else if (s < SAT_LO)
            return SAT_LO[SAMPLE_W-1:0];
        else
            return s[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/voice_ram.sv
// Per-voice phase and increment tables with registered read.
// Phase has a write-back port; increment has the config port.
import audio_pkg::*;

module voice_ram (
    input  logic               clk,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [PHASE_W-1:0] rd_phase,
    output logic [PHASE_W-1:0] rd_inc,
    input  logic               wb_en,
    input  logic [IDX_W-1:0]   wb_idx,
    input  logic [PHASE_W-1:0] wb_phase,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [PHASE_W-1:0] cfg_inc
);

    logic [PHASE_W-1:0] phase_mem [NVOICE];
    logic [PHASE_W-1:0] inc_mem   [NVOICE];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_phase <= phase_mem[rd_idx];
            rd_inc   <= inc_mem[rd_idx];
        end
        if (wb_en)
            phase_mem[wb_idx] <= wb_phase;
        if (cfg_we)
            inc_mem[cfg_idx] <= cfg_inc;
    end

endmodule

// File: rtl/voice_mix_48k.sv
// Time-multiplexed sawtooth voices summed into one sample per frame.
// Two-stage voice pipeline: table read, then add / write-back / accumulate.
import audio_pkg::*;

module voice_mix_48k (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NSLOT-1:0]           events,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_voice,
    input  logic [PHASE_W-1:0]         cfg_inc,
    input  logic                       cfg_gate,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid
);

    logic                       hit;
    logic [IDX_W-1:0]           idx;
    logic                       cfg_ok;
    logic [NVOICE-1:0]          gate;
    logic                       s1_valid;
    logic [IDX_W-1:0]           s1_idx;
    logic                       s1_gate;
    logic [PHASE_W-1:0]         rd_phase;
    logic [PHASE_W-1:0]         rd_inc;
    logic [PHASE_W-1:0]         p_next;
    logic [PHASE_W-1:0]         wb_phase;
    logic                       wb_en;
    logic signed [SAMPLE_W-1:0] voice_sample;
    logic signed [ACC_W-1:0]    acc;
    logic                       unused_ev;

    // Lowest set voice bit wins when several are asserted.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NVOICE - 1; i >= 0; i--) begin
            if (events[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

    assign cfg_ok = cfg_we &&
        ({1'b0, cfg_voice} < (IDX_W + 1)'(NVOICE));

    assign unused_ev = ^{events[NSLOT-1:EV_CLEAR+1],
                         events[EV_LATCH-1:NVOICE]};

    always_ff @(posedge clk) begin
        if (rst)
            gate <= '0;
        else if (cfg_ok)
            gate[cfg_voice] <= cfg_gate;
    end

    voice_ram u_ram (
        .clk      (clk),
        .rd_en    (hit),
        .rd_idx   (idx),
        .rd_phase (rd_phase),
        .rd_inc   (rd_inc),
        .wb_en    (wb_en),
        .wb_idx   (s1_idx),
        .wb_phase (wb_phase),
        .cfg_we   (cfg_ok),
        .cfg_idx  (cfg_voice),
        .cfg_inc  (cfg_inc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            s1_valid <= 1'b0;
        else
            s1_valid <= hit;
        s1_idx  <= idx;
        s1_gate <= gate[idx];
    end

    assign p_next       = rd_phase + rd_inc;
    assign voice_sample = p_next[PHASE_W-1 -: SAMPLE_W];
    // A write-back still in flight when reset arrives is dropped.
    assign wb_en        = s1_valid && !rst;
    assign wb_phase     = s1_gate ? p_next : '0;

    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (events[EV_CLEAR])
            acc <= '0;
        else if (s1_valid && s1_gate)
            acc <= acc + ACC_W'(voice_sample);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= events[EV_LATCH];
            if (events[EV_LATCH])
                sample_out <= sat_shift(acc);
        end
    end

endmodule

// File: tb/tb_voice_mix_48k.sv
// Scoreboard bench for voice_mix_48k with a frame-level voice model.
// Directed scenarios followed by randomized config and multi-bit slots.
module tb_voice_mix_48k;

    localparam int FRAME = 667;

    logic               clk = 1'b0;
    logic               rst;
    logic [36:0]        events;
    logic               cfg_we;
    logic [4:0]         cfg_voice;
    logic [23:0]        cfg_inc;
    logic               cfg_gate;
    logic signed [15:0] sample_out;
    logic               sample_valid;

    always #5 clk = ~clk;

    voice_mix_48k dut (
        .clk          (clk),
        .rst          (rst),
        .events       (events),
        .cfg_we       (cfg_we),
        .cfg_voice    (cfg_voice),
        .cfg_inc      (cfg_inc),
        .cfg_gate     (cfg_gate),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt      = 0;
    int cur_count = 0;
    int mphase [32];
    int minc   [32];
    bit mgate  [32];
    int msum   = 0;
    int exp_q [$];
    int last_sample = 0;
    int cyc = 0;
    int last_valid_cyc = -1;
    bit multi_en = 1'b0;

    function automatic int sat16(input int s);
        int v;
        v = s >>> 2;
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int vsample(input int p);
        int t;
        t = (p >> 8) & 'hFFFF;
        return (t >= 32768) ? t - 65536 : t;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, req, req);
        end
    endtask

    // One clock of the event generator plus the reference model.
    task automatic tick(input bit we, input int v, input int iv,
                        input bit g, input bit r);
        logic [36:0] ev;
        ev = '0;
        if (cnt < 37) ev[cnt] = 1'b1;
        if (multi_en && cnt < 31 && $urandom_range(0, 7) == 0)
            ev[$urandom_range(31, cnt + 1)] = 1'b1;
        events    = ev;
        cfg_we    = we;
        cfg_voice = 5'(v);
        cfg_inc   = 24'(iv);
        cfg_gate  = g;
        rst       = r;
        cur_count = cnt;
        if (r) begin
            for (int i = 0; i < 32; i++) mgate[i] = 1'b0;
            msum = 0;
        end else begin
            if (cnt < 32) begin
                if (mgate[cnt]) begin
                    mphase[cnt] = (mphase[cnt] + minc[cnt]) & 'hFFFFFF;
                    msum += vsample(mphase[cnt]);
                end else begin
                    mphase[cnt] = 0;
                end
            end
            if (cnt == 33) exp_q.push_back(sat16(msum));
            if (cnt == 34) msum = 0;
            if (we) begin
                mgate[v] = g;
                minc[v]  = iv;
            end
        end
        @(posedge clk);
        #1;
        cnt = (cnt + 1) % FRAME;
    endtask

    task automatic run_to(input int t);
        do tick(0, 0, 0, 0, 0); while (cnt != t);
    endtask

    task automatic frame_end();
        run_to(35);
    endtask

    task automatic wr(input int v, input int iv, input bit g);
        tick(1, v, iv, g, 0);
    endtask

    task automatic all_voices(input int iv, input bit g);
        for (int v = 0; v < 32; v++) wr(v, iv, g);
    endtask

    always @(negedge clk) begin : monitor
        cyc++;
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got sample %0d, expected none",
                         sample_out);
            end else begin
                check("sample", int'(sample_out), exp_q.pop_front());
            end
            check("valid_slot", cur_count, 34);
            if (last_valid_cyc >= 0)
                check("valid_period", cyc - last_valid_cyc, FRAME);
            last_valid_cyc = cyc;
            last_sample = int'(sample_out);
        end
    end

    initial begin
        rst = 1'b1;
        events = '0;
        cfg_we = 1'b0;
        cfg_voice = '0;
        cfg_inc = '0;
        cfg_gate = 1'b0;

        repeat (3) tick(0, 0, 0, 0, 1);
        check("reset_sample", int'(sample_out), 0);
        check("reset_valid", int'(sample_valid), 0);

        frame_end();
        check("idle_f1", last_sample, 0);
        frame_end();
        check("idle_f2", last_sample, 0);

        run_to(40);
        wr(0, 'h010000, 1);
        frame_end();
        check("v0_f1", last_sample, 'h40);
        frame_end();
        check("v0_f2", last_sample, 'h80);
        frame_end();
        check("v0_f3", last_sample, 'hC0);

        wr(0, 'h010000, 0);
        frame_end();
        check("gate_off", last_sample, 0);
        wr(0, 'h010000, 1);
        frame_end();
        check("regate", last_sample, 'h40);

        all_voices(0, 0);
        frame_end();
        all_voices('h7FFF00, 1);
        frame_end();
        check("sat_hi", last_sample, 32767);
        all_voices(0, 0);
        frame_end();
        all_voices('h800000, 1);
        frame_end();
        check("sat_lo", last_sample, -32768);

        all_voices(0, 0);
        frame_end();
        wr(5, 'h010000, 1);
        frame_end();
        check("v5_old", last_sample, 'h40);
        run_to(5);
        wr(5, 'h020000, 1);
        frame_end();
        check("v5_same_slot", last_sample, 'h80);
        frame_end();
        check("v5_new_inc", last_sample, 'h100);

        wr(0, 'h123456, 1);
        wr(25, 'h0ABCDE, 1);
        frame_end();
        run_to(20);
        tick(0, 0, 0, 0, 1);
        check("midrst_sample", int'(sample_out), 0);
        check("midrst_valid", int'(sample_valid), 0);
        frame_end();
        check("post_rst_f1", last_sample, 0);
        frame_end();
        check("post_rst_f2", last_sample, 0);

        multi_en = 1'b1;
        repeat (6 * FRAME) begin
            if ($urandom_range(0, 7) == 0)
                wr($urandom_range(0, 31), int'($urandom & 'hFFFFFF),
                   1'($urandom_range(0, 1)));
            else
                tick(0, 0, 0, 0, 0);
        end
        multi_en = 1'b0;
        frame_end();
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
